// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: pops a read-latency-1 FIFO into a 2-entry valid/ready stream
// and flags every FRAME_LEN-th beat with m_last to delimit matrix rows.
module fifo_stream_adapter #(
   parameter int DATA_LEN  = 8,
   parameter int FRAME_LEN = 4,
   parameter int CNT_WIDTH = 2
) (
   input  logic                clk,
   input  logic                sys_rst_n,
   input  logic                soft_clr,
   input  logic                fifo_empty,
   input  logic [DATA_LEN-1:0] fifo_data,
   output logic                fifo_rd_en,
   output logic                m_valid,
   output logic [DATA_LEN-1:0] m_data,
   output logic                m_last,
   input  logic                m_ready
);
   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);
   logic [1:0] occ;
   logic inflight, rst_done, pop, shift, load_head, load_tail;
   logic [CNT_WIDTH-1:0] beat_cnt;
   logic [DATA_LEN-1:0] head, tail;
   always_comb begin
      m_valid = occ != 2'd0;
      m_data = head;
      pop = m_valid & m_ready;
      m_last = m_valid & (beat_cnt == LAST_BEAT);
      // a read is only issued when its word is guaranteed a buffer slot on arrival
      fifo_rd_en = rst_done & ~soft_clr & ~fifo_empty &
                   (({1'b0, occ} + {2'b00, inflight}) < (pop ? 3'd3 : 3'd2));
      shift = pop & (occ == 2'd2);
      load_head = shift | (inflight & ((occ == 2'd0) | (pop & (occ == 2'd1))));
      load_tail = inflight & (((occ == 2'd1) & ~pop) | shift);
   end
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         occ <= 2'd0;
         inflight <= 1'b0;
         rst_done <= 1'b0;
         beat_cnt <= '0;
         head <= '0;
         tail <= '0;
      end else begin
         rst_done <= 1'b1;
         if (soft_clr) begin
            occ <= 2'd0;
            inflight <= 1'b0;
            beat_cnt <= '0;
         end else begin
            inflight <= fifo_rd_en;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
            if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            if (load_head) head <= shift ? tail : fifo_data;
            if (load_tail) tail <= fifo_data;
         end
      end
   end
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter: scoreboard bench; a FIFO model feeds the adapter and a
// monitor compares every accepted beat (data and m_last) against the expected queue.
module tb_fifo_stream_adapter;
   localparam int DL = 8;
   localparam int FL = 4;
   logic clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic soft_clr = 1'b0;
   logic m_ready = 1'b1;
   logic fifo_empty = 1'b1;
   logic [DL-1:0] fifo_data = '0;
   logic fifo_rd_en, m_valid, m_last;
   logic [DL-1:0] m_data;
   logic [DL-1:0] fmem[$];
   logic [DL:0] exp_q[$];
   logic [DL:0] mon_exp;
   int checks = 0;
   int errors = 0;
   int n_acc = 0;
   int acc0 = 0;
   int push_beat = 0;

   always #5 clk = ~clk;

   fifo_stream_adapter #(.DATA_LEN(DL), .FRAME_LEN(FL), .CNT_WIDTH(2)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .soft_clr(soft_clr), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
      .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
   );

   // FIFO model: data appears the cycle after an accepted read, 0 otherwise
   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty && fmem.size() != 0) begin
         fifo_data <= fmem.pop_front();
         n_acc++;
      end else begin
         fifo_data <= '0;
      end
      fifo_empty <= fmem.size() == 0;
   end

   always @(negedge clk) begin
      if (sys_rst_n && m_valid && m_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: got data=%h last=%b, required no beat", m_data, m_last);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({m_last, m_data} !== mon_exp) begin
               errors++;
               $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                        m_data, m_last, mon_exp[DL-1:0], mon_exp[DL]);
            end
         end
      end
      if (dut.occ > 2'd2) begin
         errors++;
         $display("FAIL occ_bound: got %0d, required <= 2", dut.occ);
      end
   end

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(logic [DL-1:0] w, bit keep);
      fmem.push_back(w);
      if (keep) begin
         exp_q.push_back({push_beat == FL - 1, w});
         push_beat = (push_beat + 1) % FL;
      end
   endtask

   task automatic drain(string name, int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d beats outstanding, required 0", name, exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic assert_reset();
      sys_rst_n = 1'b0;
      fmem.delete();
      exp_q.delete();
      push_beat = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1);
   end

   initial begin
      // 1: preloaded FIFO, first-read and first-beat latency
      assert_reset();
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      push(8'h33, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;
      #1;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_last", m_last, 0);
      @(negedge clk);
      chk("t1_rd_en_c1", fifo_rd_en, 1);
      chk("t1_valid_c1", m_valid, 0);
      @(negedge clk);
      chk("t1_valid_c2", m_valid, 0);
      @(negedge clk);
      chk("t1_valid_c3", m_valid, 1);
      chk("t1_data_c3", m_data, 'h11);
      @(negedge clk);
      chk("t1_valid_c4", m_valid, 1);
      chk("t1_rd_en_c4", fifo_rd_en, 0);
      @(negedge clk);
      chk("t1_valid_c5", m_valid, 1);
      chk("t1_rd_en_c5", fifo_rd_en, 0);
      @(negedge clk);
      chk("t1_valid_c6", m_valid, 0);
      drain("t1_drain", 20);
      // 2: two full frames, m_last on beats 3 and 7
      assert_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) push(DL'(32'h20 + i), 1'b1);
      drain("t2_drain", 40);
      // 3: stalled sink, only two reads accepted
      @(posedge clk);
      #1 m_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 5; i++) push(DL'(32'h40 + i), 1'b1);
      repeat (5) @(posedge clk);
      #1 chk("t3_hold_mid", m_data, 'h40);
      repeat (5) @(posedge clk);
      #1 chk("t3_accepts", n_acc - acc0, 2);
      chk("t3_valid", m_valid, 1);
      chk("t3_hold_end", m_data, 'h40);
      m_ready = 1'b1;
      drain("t3_drain", 40);
      // 4: m_ready toggling every cycle
      for (int i = 0; i < 16; i++) push(DL'(32'h60 + 3 * i), 1'b1);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1 m_ready = ~m_ready;
      end
      @(posedge clk);
      #1 m_ready = 1'b1;
      drain("t4_drain", 20);
      // 5: soft_clr with one word buffered and one in flight
      push(8'h80, 1'b1);
      drain("t5_pre", 20);
      @(posedge clk);
      #1 m_ready = 1'b0;
      push(8'h81, 1'b0);
      push(8'h82, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_valid) break;
      end
      chk("t5_valid_pre_clr", m_valid, 1);
      chk("t5_data_pre_clr", m_data, 'h81);
      soft_clr = 1'b1;
      @(negedge clk);
      soft_clr = 1'b0;
      chk("t5_valid_post_clr", m_valid, 0);
      chk("t5_last_post_clr", m_last, 0);
      push_beat = 0;
      @(posedge clk);
      #1 m_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(DL'(32'h90 + i), 1'b1);
      drain("t5_drain", 30);
      // 6: async reset at beat 2 of a frame
      for (int i = 0; i < 6; i++) push(DL'(32'hA0 + i), 1'b1);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_valid && m_data == 8'hA2) break;
      end
      chk("t6_pre_data", m_data, 'hA2);
      chk("t6_pre_rd_en", fifo_rd_en, 1);
      #2 assert_reset();
      #1;
      chk("t6_rst_valid", m_valid, 0);
      chk("t6_rst_last", m_last, 0);
      chk("t6_rst_rd_en", fifo_rd_en, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) push(DL'(32'hB0 + i), 1'b1);
      drain("t6_drain", 30);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
